// File: rtl/ysyx_25040111_burst_rsp.sv
// ysyx_25040111_burst_rsp
//   Responder for the per-beat cache refill protocol. The first rstart of a
//   refill opens one INCR AXI4 read burst of rlen+1 beats. Returned beats are
//   buffered in a small FIFO. Each rstart is answered by exactly one rok pulse
//   carrying the next word in burst order.
//
// Configuration macro:
//   YSYX_25040111_ADDRCHK_EN - when defined, every rstart after the first is
//   checked against the expected sequential beat address. A mismatch sets err.
//
// Ports:
//   clock, reset        clock; synchronous active-high reset
//   rstart/raddr/rlen   beat request, beat address, refill length-1
//   rok/rdata           one-cycle response pulse and returned word
//   err                 sticky error flag (bad rresp, rlast, over-request, address)
//   ar*                 AXI4 read address channel (arid is tied to 0)
//   rvalid/rready/rdata_i/rresp/rlast  AXI4 read data channel
module ysyx_25040111_burst_rsp #(
  parameter int BUF_AW = 2,
  parameter int ID_W   = 4
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            rstart,
  input  logic [31:0]     raddr,
  input  logic [7:0]      rlen,
  output logic            rok,
  output logic [31:0]     rdata,
  output logic            err,
  output logic            arvalid,
  input  logic            arready,
  output logic [31:0]     araddr,
  output logic [7:0]      arlen,
  output logic [2:0]      arsize,
  output logic [1:0]      arburst,
  output logic [ID_W-1:0] arid,
  input  logic            rvalid,
  output logic            rready,
  input  logic [31:0]     rdata_i,
  input  logic [1:0]      rresp,
  input  logic            rlast
);

  localparam int             DEPTH   = 1 << BUF_AW;
  localparam logic [BUF_AW:0] PTR_ONE = (BUF_AW + 1)'(1);

  typedef enum logic [1:0] {IDLE, AR, DATA} state_t;

  state_t          state;
  logic [31:0]     mem [DEPTH];
  logic [BUF_AW:0] wptr, rptr;
  logic [8:0]      total;   // beats in this refill (rlen+1, up to 256)
  logic [8:0]      served;  // rok pulses already issued
  logic [8:0]      pend;    // accepted rstarts not yet answered
  logic [8:0]      rcvd;    // beats accepted from the R channel

  logic fifo_empty, fifo_full, push, serve;
  logic over_req, req_ok, last_beat, beat_err, addr_err;

  assign arsize  = 3'b010;
  assign arburst = 2'b01;
  assign arid    = '0;

  // Extra-bit pointers: equal means empty, equal except for the MSB means full.
  assign fifo_empty = (wptr == rptr);
  assign fifo_full  = (wptr[BUF_AW] != rptr[BUF_AW]) &&
                      (wptr[BUF_AW-1:0] == rptr[BUF_AW-1:0]);

  // Stop accepting once the whole burst is in, so stray beats are never buffered.
  assign rready = (state == DATA) && !fifo_full && (rcvd != total);
  assign push   = rvalid && rready;

  // A request beyond the refill's remaining beats is dropped and flagged.
  assign over_req = (state != IDLE) && rstart && (pend == total - served);
  assign req_ok   = (state != IDLE) && rstart && !over_req;

  // A beat arriving into an empty FIFO is served straight through in the same
  // cycle, which keeps first-beat latency at one cycle after the R handshake.
  assign serve = (state == DATA) && ((pend != 9'd0) || req_ok) && (!fifo_empty || push);

  assign last_beat = (rcvd + 9'd1 == total);
  assign beat_err  = push && ((rresp != 2'b00) || (rlast != last_beat));

`ifdef YSYX_25040111_ADDRCHK_EN
  // served+pend is the index of the beat this rstart asks for; it does not
  // change when a serve coincides with the request.
  logic [31:0] exp_addr;
  assign exp_addr = araddr + {21'd0, served + pend, 2'b00};
  assign addr_err = req_ok && (raddr != exp_addr);
`else
  assign addr_err = 1'b0;
`endif

  // NOTE: the buffer is small, so it is cleared with the rest of the state;
  // the pointers alone already guarantee stale words are never read.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push) begin
      mem[wptr[BUF_AW-1:0]] <= rdata_i;
    end
  end

  // NOTE: all state uses non-blocking assignments so every register samples
  // the pre-edge values; later assignments in this block override earlier ones.
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      rok     <= 1'b0;
      rdata   <= '0;
      err     <= 1'b0;
      arvalid <= 1'b0;
      araddr  <= '0;
      arlen   <= '0;
      wptr    <= '0;
      rptr    <= '0;
      total   <= '0;
      served  <= '0;
      pend    <= '0;
      rcvd    <= '0;
    end else begin
      rok  <= serve;
      pend <= pend + {8'd0, req_ok} - {8'd0, serve};

      if (serve) begin
        rdata  <= fifo_empty ? rdata_i : mem[rptr[BUF_AW-1:0]];
        rptr   <= rptr + PTR_ONE;
        served <= served + 9'd1;
      end

      if (push) begin
        wptr <= wptr + PTR_ONE;
        rcvd <= rcvd + 9'd1;
      end

      if (beat_err || over_req || addr_err) err <= 1'b1;

      unique case (state)
        IDLE: if (rstart) begin
          araddr  <= raddr;
          arlen   <= rlen;
          total   <= {1'b0, rlen} + 9'd1;
          served  <= '0;
          rcvd    <= '0;
          pend    <= 9'd1;
          arvalid <= 1'b1;
          state   <= AR;
        end
        AR: if (arready) begin
          arvalid <= 1'b0;
          state   <= DATA;
        end
        DATA: if (served == total) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
